// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PS/2 keycode receiver.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : prefix byte values stripped from the stream
//   PS2_FRAME_BITS                  : start + 8 data + parity + stop
//   prefix_state_t                  : prefix FSM state encoding
//   is_prefix()                     : 1 when a byte is one of the two prefixes
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Deserialises 11-bit PS/2 device-to-host frames and checks start, odd parity
// and stop. Produces one byte per good frame, or a frame error.
//
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   i_ps2_clk       raw PS/2 clock pin (asynchronous)
//   i_ps2_data      raw PS/2 data pin (asynchronous)
//   o_byte          received data byte, valid while o_byte_rdy is high
//   o_byte_rdy      1-cycle pulse, one cycle after the stop-bit fall strobe
//   o_frame_err     1-cycle pulse on a bad frame (or watchdog timeout)
//
// Build option PS2_RX_TIMEOUT_EN: adds an inactivity watchdog that discards a
// partial frame after TIMEOUT_CYCLES clocks without a PS/2 clock fall.
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_rdy,
    output logic       o_frame_err
);

    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("ps2_frame_rx: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("ps2_frame_rx: TIMEOUT_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;
    logic                   w_timeout;

    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_start;
    logic       r_parity;
    logic       r_byte_rdy;
    logic       r_frame_err;

    // Synchronisers reset to the idle-high bus level so leaving reset never
    // looks like a clock fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned          TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]      TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_idle_cnt;

    // Down-counter holds the clocks remaining before timeout; it is reloaded
    // on every fall and while no frame is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= TO_LOAD;
        end else if (w_fall || (r_bit_cnt == 4'd0)) begin
            r_idle_cnt <= TO_LOAD;
        end else if (r_idle_cnt != '0) begin
            r_idle_cnt <= r_idle_cnt - 1'b1;
        end
    end

    // A fall in the terminal cycle wins over the timeout.
    assign w_timeout = (r_bit_cnt != 4'd0) && (r_idle_cnt == '0) && !w_fall;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_start     <= 1'b0;
            r_parity    <= 1'b0;
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                if (r_bit_cnt == 4'd0) begin
                    r_start   <= w_data_s;
                    r_parity  <= 1'b0;
                    r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt == LAST_BIT) begin
                    // r_parity is the XOR of data and parity bits: must be 1
                    if (!r_start && r_parity && w_data_s) begin
                        r_byte_rdy <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                    r_bit_cnt <= 4'd0;
                end else begin
                    r_parity <= r_parity ^ w_data_s;
                    if (r_bit_cnt <= 4'd8) begin
                        r_shift <= {w_data_s, r_shift[7:1]};
                    end
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_timeout) begin
                r_bit_cnt   <= 4'd0;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign o_byte      = r_shift;
    assign o_byte_rdy  = r_byte_rdy;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_keycode_receiver.sv
// ---------------------------------------------------------------------------
// ps2_keycode_receiver
// PS/2 keyboard receiver: turns raw frames into one event per key action,
// stripping the E0 (extended) and F0 (break) prefix bytes.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   keycode      last keycode, held until the next event
//   make         1 = press, 0 = release (held level)
//   extended     1 = last event was E0-prefixed (held)
//   key_valid    1-cycle pulse when keycode/make/extended update
//   frame_err    1-cycle pulse on a rejected frame
//
// Build option PS2_RX_TIMEOUT_EN enables the mid-frame inactivity watchdog in
// ps2_frame_rx.
//
// Prefix FSM:
//   state   | meaning
//   IDLE    | no prefix pending
//   EXT     | E0 seen, next keycode is extended make
//   BRK     | F0 seen, next keycode is a release
//   EXT_BRK | E0 and F0 seen, next keycode is extended release
// ---------------------------------------------------------------------------
module ps2_keycode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       make,
    output logic       extended,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_rdy;
    logic       w_frame_err;

    prefix_state_t r_state;
    logic [7:0]    r_keycode;
    logic          r_make;
    logic          r_extended;
    logic          r_key_valid;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_byte      (w_byte),
        .o_byte_rdy  (w_byte_rdy),
        .o_frame_err (w_frame_err)
    );

    // Extended and break flags accumulate independently, so prefix order
    // (E0 F0 vs F0 E0) and repeated prefixes do not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_keycode   <= 8'h00;
            r_make      <= 1'b0;
            r_extended  <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_err) begin
                r_state <= IDLE;
            end else if (w_byte_rdy) begin
                if (w_byte == PS2_PREFIX_EXT) begin
                    r_state <= (r_state == BRK || r_state == EXT_BRK) ? EXT_BRK : EXT;
                end else if (w_byte == PS2_PREFIX_BRK) begin
                    r_state <= (r_state == EXT || r_state == EXT_BRK) ? EXT_BRK : BRK;
                end else begin
                    r_keycode   <= w_byte;
                    r_make      <= !(r_state == BRK || r_state == EXT_BRK);
                    r_extended  <= (r_state == EXT || r_state == EXT_BRK);
                    r_key_valid <= !is_prefix(w_byte);
                    r_state     <= IDLE;
                end
            end
        end
    end

    assign keycode   = r_keycode;
    assign make      = r_make;
    assign extended  = r_extended;
    assign key_valid = r_key_valid;
    assign frame_err = w_frame_err;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
module tb_ps2_keycode_receiver;

    localparam int SYNC = 2;
    localparam int TO   = 100;
    localparam int HALF = 8;
    localparam int LAT_KEY = SYNC + 2;
    localparam int LAT_ERR = SYNC + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       make;
    logic       extended;
    logic       key_valid;
    logic       frame_err;

    ps2_keycode_receiver #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .make      (make),
        .extended  (extended),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       mk;
        logic       ex;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stop_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (key_valid || frame_err)) begin
            n_cmp++;
            if (key_valid && frame_err) begin
                n_fail++;
                $display("FAIL both_pulses: key_valid=%b frame_err=%b, required not both", key_valid, frame_err);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: key_valid=%b frame_err=%b keycode=%h, required no pulse",
                         key_valid, frame_err, keycode);
            end else begin
                e = sb.pop_front();
                if (frame_err !== e.is_err) begin
                    n_fail++;
                    $display("FAIL pulse_kind: frame_err=%b, required %b", frame_err, e.is_err);
                end else if (!e.is_err) begin
                    n_cmp += 3;
                    if (keycode !== e.code) begin
                        n_fail++;
                        $display("FAIL keycode: got %h, required %h", keycode, e.code);
                    end
                    if (make !== e.mk) begin
                        n_fail++;
                        $display("FAIL make: got %b, required %b (code %h)", make, e.mk, e.code);
                    end
                    if (extended !== e.ex) begin
                        n_fail++;
                        $display("FAIL extended: got %b, required %b (code %h)", extended, e.ex, e.code);
                    end
                end
                if (e.lat > 0) begin
                    n_cmp++;
                    if (cyc - stop_cyc !== e.lat) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles after stop fall, required %0d", cyc - stop_cyc, e.lat);
                    end
                end
            end
        end
    end

    task automatic push_key(input logic [7:0] c, input logic m, input logic x);
        sb.push_back('{is_err: 1'b0, code: c, mk: m, ex: x, lat: LAT_KEY});
    endtask

    task automatic push_err(input int lat);
        sb.push_back('{is_err: 1'b1, code: 8'h00, mk: 1'b0, ex: 1'b0, lat: lat});
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        stop_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        logic        p;
        p = ~(^b) ^ bad_par;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
    endtask

    task automatic drain(input string name);
        repeat (20) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp += 5;
        if (keycode   !== 8'h00) begin n_fail++; $display("FAIL reset_keycode: got %h, required 00", keycode); end
        if (make      !== 1'b0)  begin n_fail++; $display("FAIL reset_make: got %b, required 0", make); end
        if (extended  !== 1'b0)  begin n_fail++; $display("FAIL reset_extended: got %b, required 0", extended); end
        if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
        if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_make();
        push_key(8'h1B, 1'b1, 1'b0);
        send_frame(8'h1B, 1'b0, 11);
        drain("drain_make");
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 11);
        push_key(8'h1B, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 11);
        drain("drain_break");
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0, 11);
        push_key(8'h75, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 11);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        push_key(8'h75, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 11);
        drain("drain_extended");
    endtask

    task automatic test_parity_err();
        send_frame(8'hE0, 1'b0, 11);
        push_err(LAT_ERR);
        send_frame(8'h72, 1'b1, 11);
        drain("drain_parity");
        @(negedge clk);
        n_cmp += 3;
        if (keycode !== 8'h75)   begin n_fail++; $display("FAIL hold_keycode: got %h, required 75", keycode); end
        if (make !== 1'b0)       begin n_fail++; $display("FAIL hold_make: got %b, required 0", make); end
        if (extended !== 1'b1)   begin n_fail++; $display("FAIL hold_extended: got %b, required 1", extended); end
        // pending E0 must have been discarded by the error
        push_key(8'h33, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 11);
        drain("drain_after_err");
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [5];
        codes = '{8'h00, 8'hE1, 8'hAA, 8'h1C, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 1) send_frame(8'hF0, 1'b0, 11);
            push_key(codes[i], (i % 2 == 0), 1'b0);
            send_frame(codes[i], 1'b0, 11);
        end
        drain("drain_back_to_back");
    endtask

`ifdef PS2_RX_TIMEOUT_EN
    task automatic test_timeout();
        push_err(0);
        send_frame(8'h6B, 1'b0, 4);
        repeat (TO + 50) @(posedge clk);
        drain("drain_timeout_err");
        push_key(8'h6B, 1'b1, 1'b0);
        send_frame(8'h6B, 1'b0, 11);
        drain("drain_timeout");
    endtask
`endif

    task automatic test_reset_midframe();
        send_frame(8'h74, 1'b0, 5);
        @(posedge clk); #1 rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 5;
        if (keycode   !== 8'h00) begin n_fail++; $display("FAIL midrst_keycode: got %h, required 00", keycode); end
        if (make      !== 1'b0)  begin n_fail++; $display("FAIL midrst_make: got %b, required 0", make); end
        if (extended  !== 1'b0)  begin n_fail++; $display("FAIL midrst_extended: got %b, required 0", extended); end
        if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_key_valid: got %b, required 0", key_valid); end
        if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL midrst_frame_err: got %b, required 0", frame_err); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        push_key(8'h74, 1'b1, 1'b0);
        send_frame(8'h74, 1'b0, 11);
        drain("drain_midreset");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_err();
        test_back_to_back();
`ifdef PS2_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ps2_keycode_receiver.md
Name: ps2_keycode_receiver

Overview:
- PS/2 keyboard-side receiver. Deserialises raw PS/2 device-to-host frames and strips the 0xE0 (extended) and 0xF0 (break) prefix bytes.
- Emits one event per key action: an 8-bit keycode plus a make/break level.
- Sits between the PS/2 connector pins and the keycode decoder that produces the up/down/left/right/start_game controls.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles of PS/2 clock inactivity mid-frame before the partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on ps2_clk and ps2_data; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- keycode  output  8  last decoded keycode, prefixes stripped; held until the next event.
- make  output  1  1 = last event was a press, 0 = release; held.
- extended  output  1  1 = last event was E0-prefixed; held.
- key_valid  output  1  one-cycle pulse; keycode/make/extended updated this cycle.
- frame_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous, active-low, on rst_n.
  - Reset values: keycode=0x00, make=0, extended=0, key_valid=0, frame_err=0. Bit counter=0, prefix FSM=IDLE.
  - Reset mid-frame discards all partial state.
- Input sampling:
  - Both pins pass through SYNC_STAGES flops.
  - A falling edge is detected on synced ps2_clk (previous 1, current 0). This gives a 1-cycle fall strobe.
  - Data is sampled on fall.
- Frame format, 11 bits, LSB first:
  - start bit = 0
  - d[7:0]
  - odd parity (XOR of d and parity = 1)
  - stop bit = 1
- Bit counter:
  - Counts 0..10 and wraps to 0 after the stop bit.
  - Check on the stop bit: start==0, parity odd, stop==1.
  - Pass: internal byte_rdy pulse one cycle after the stop-bit fall.
  - Fail: frame_err pulse one cycle after the stop-bit fall. The byte is dropped and the prefix FSM returns to IDLE.
- Prefix FSM, advancing on byte_rdy:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> emit (make=1, ext=0).
  - EXT: F0 -> EXT_BRK; E0 -> stay; other -> emit (make=1, ext=1), go to IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> stay; other -> emit (make=0, ext=0), go to IDLE.
  - EXT_BRK: E0/F0 -> stay; other -> emit (make=0, ext=1), go to IDLE.
  - Emit: keycode/make/extended are registered and key_valid pulses in the cycle after byte_rdy.
- Latency: key_valid is high exactly 2 clk cycles after the fall strobe of the final stop bit. Prefix bytes produce no key_valid.
- Simultaneous events: key_valid and frame_err are never high together, because a failing frame generates no byte_rdy.
- Byte values:
  - All non-prefix bytes, including 0x00, 0xE1 and 0xAA, are emitted as ordinary keycodes.
  - make is a level, not a pulse; it stays 1 while a key is held.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while the bit counter != 0 and clears on every fall.
  - When it reaches TIMEOUT_CYCLES-1, the bit counter resets to 0, the FSM goes to IDLE, and frame_err pulses for one cycle.
  - A fall in that same cycle takes priority: the counter clears and no timeout fires.
- Undefined:
  - No counter. A lost edge misaligns framing until a parity, start or stop check fails.

Decomposition:
- Package ps2_pkg contains:
  - PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_FRAME_BITS=11
  - prefix FSM state enum {IDLE, EXT, BRK, EXT_BRK}
- Sub-module ps2_frame_rx: synchronisers, edge detect, shift register, parity/start/stop check and optional watchdog. It outputs byte, byte_rdy and frame_err.
- The top level holds only the prefix FSM and the output registers.

Test Plan:
- Frame 0x1B with correct parity -> key_valid exactly 2 cycles after the stop-bit fall; keycode=0x1B, make=1, extended=0.
- Frames F0, 1B -> a single key_valid; keycode=0x1B, make=0, extended=0. No pulse after the F0 byte.
- Frames E0 75, then E0 F0 75 -> two key_valids: (0x75, make=1, ext=1), then (0x75, make=0, ext=1).
- Frame 0x72 with parity bit inverted -> frame_err pulse and no key_valid. Outputs keep their prior values and the FSM is in IDLE.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: 4 bits, then ps2_clk held high for 100+ cycles -> frame_err pulse. A following valid frame 0x6B decodes correctly (make=1).
- rst_n asserted low after 5 bits of a frame, then released, then full frame 0x74 -> all outputs 0 during reset; then keycode=0x74, make=1.
